// File: rtl/chacha_round_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// chacha_round_sequencer
//
// Control FSM that walks the ChaCha20 quarter-round datapath through one
// keystream block: LOAD -> ROUNDS x 4 quarter-rounds (QR) -> feed-forward ADD
// -> OUT handshake. The datapath is fully slaved to the strobes below.
//
// Parameters
//   ROUNDS    rounds per block; even, >= 2. Even rounds are column rounds,
//             odd rounds are diagonal rounds.
//   QR_CYCLES clock cycles the datapath spends per quarter-round; >= 1.
//   RW        width of round_idx; 2**RW >= ROUNDS.
//
// Ports
//   clk, reset_n  clock (rising edge), asynchronous active-low reset
//   start         request one block; only looked at in IDLE
//   abort         synchronous abort back to IDLE, clears all counters
//   ks_ready      consumer accepts the keystream block
//   busy          high in every state except IDLE
//   load_state    one-cycle strobe: load key/nonce/counter
//   qr_en         datapath performs/advances a quarter-round this cycle
//   qr_idx        quarter-round index 0..3 within the current round
//   diag          0 = column round, 1 = diagonal round (round_idx[0])
//   round_idx     current round 0..ROUNDS-1
//   add_en        one-cycle strobe: working state += original state
//   ks_valid      keystream block valid, held until accepted
//   block_inc     one-cycle pulse on the ks_valid && ks_ready handshake
//   done          one-cycle pulse, same cycle as block_inc
//
// Optional feature (macro CHACHA_SEQ_BLKCNT_EN)
//   Adds output blk_cnt[31:0], a free-running count of completed blocks.
//   It resets to 0, wraps at 2**32 and is not cleared by abort.
// -----------------------------------------------------------------------------
module chacha_round_sequencer #(
  parameter int ROUNDS    = 20,
  parameter int QR_CYCLES = 1,
  parameter int RW        = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic          ks_ready,
  output logic          busy,
  output logic          load_state,
  output logic          qr_en,
  output logic [1:0]    qr_idx,
  output logic          diag,
  output logic [RW-1:0] round_idx,
  output logic          add_en,
  output logic          ks_valid,
  output logic          block_inc,
  output logic          done
`ifdef CHACHA_SEQ_BLKCNT_EN
  ,
  output logic [31:0]   blk_cnt
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_QR   = 3'd2;
  localparam logic [2:0] S_ADD  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  // Sub-cycle counter needs at least one bit even when QR_CYCLES == 1.
  localparam int          SW         = (QR_CYCLES > 1) ? $clog2(QR_CYCLES) : 1;
  localparam logic [SW-1:0] SUB_LAST   = SW'(QR_CYCLES - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [1:0]    qr_idx_q, qr_idx_d;
  logic [RW-1:0] round_idx_q, round_idx_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d     = state_q;
    sub_d       = sub_q;
    qr_idx_d    = qr_idx_q;
    round_idx_d = round_idx_q;

    if (abort) begin
      state_d     = S_IDLE;
      sub_d       = '0;
      qr_idx_d    = '0;
      round_idx_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_d = S_LOAD;
        end
        S_LOAD: begin
          sub_d       = '0;
          qr_idx_d    = '0;
          round_idx_d = '0;
          state_d     = S_QR;
        end
        S_QR: begin
          if (sub_q == SUB_LAST) begin
            sub_d = '0;
            if (qr_idx_q == 2'd3) begin
              // Final quarter-round of the final round: hold the indices so
              // the datapath still sees the last round during ADD.
              if (round_idx_q == ROUND_LAST) begin
                state_d = S_ADD;
              end else begin
                qr_idx_d    = 2'd0;
                round_idx_d = round_idx_q + RW'(1);
              end
            end else begin
              qr_idx_d = qr_idx_q + 2'd1;
            end
          end else begin
            sub_d = sub_q + SW'(1);
          end
        end
        S_ADD: begin
          state_d = S_OUT;
        end
        S_OUT: begin
          // A start arriving with the handshake is deliberately dropped.
          if (ks_ready) begin
            state_d     = S_IDLE;
            sub_d       = '0;
            qr_idx_d    = '0;
            round_idx_d = '0;
          end
        end
        default: begin
          state_d     = S_IDLE;
          sub_d       = '0;
          qr_idx_d    = '0;
          round_idx_d = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sub_q       <= '0;
      qr_idx_q    <= '0;
      round_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      qr_idx_q    <= qr_idx_d;
      round_idx_q <= round_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, except the handshake pulses.
  // ---------------------------------------------------------------------------
  assign busy       = (state_q != S_IDLE);
  assign load_state = (state_q == S_LOAD);
  assign qr_en      = (state_q == S_QR);
  assign add_en     = (state_q == S_ADD);
  assign ks_valid   = (state_q == S_OUT);
  assign qr_idx     = qr_idx_q;
  assign round_idx  = round_idx_q;
  assign diag       = round_idx_q[0];

  // An abort in the handshake cycle wins, so no completion is reported.
  assign block_inc  = ks_valid && ks_ready && !abort;
  assign done       = block_inc;

`ifdef CHACHA_SEQ_BLKCNT_EN
  logic [31:0] blk_cnt_q, blk_cnt_d;

  always_comb begin
    blk_cnt_d = block_inc ? blk_cnt_q + 32'd1 : blk_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blk_cnt_q <= '0;
    else          blk_cnt_q <= blk_cnt_d;
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_chacha_round_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_chacha_round_sequencer
//
// Self-checking bench for chacha_round_sequencer. Two instances share clock
// and reset: dut_a with default parameters, dut_b with ROUNDS=8, QR_CYCLES=3.
// A select bit steers stimulus and observation to one instance at a time.
// Expected ks_valid latencies are queued when a start is issued and popped
// when the block appears at the output.
// -----------------------------------------------------------------------------
module tb_chacha_round_sequencer;

  localparam int RW  = 5;
  localparam int A_R = 20;
  localparam int A_Q = 1;
  localparam int B_R = 8;
  localparam int B_Q = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic a_start = 1'b0, a_abort = 1'b0, a_ready = 1'b0;
  logic b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b0;

  logic          a_busy, a_load, a_qr_en, a_diag, a_add, a_ks_valid, a_block_inc, a_done;
  logic [1:0]    a_qr_idx;
  logic [RW-1:0] a_round_idx;
  logic          b_busy, b_load, b_qr_en, b_diag, b_add, b_ks_valid, b_block_inc, b_done;
  logic [1:0]    b_qr_idx;
  logic [RW-1:0] b_round_idx;
`ifdef CHACHA_SEQ_BLKCNT_EN
  logic [31:0]   a_blk_cnt, b_blk_cnt;
`endif

  always #5 clk = ~clk;

  chacha_round_sequencer #(.ROUNDS(A_R), .QR_CYCLES(A_Q), .RW(RW)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .abort(a_abort),
    .ks_ready(a_ready), .busy(a_busy), .load_state(a_load), .qr_en(a_qr_en),
    .qr_idx(a_qr_idx), .diag(a_diag), .round_idx(a_round_idx), .add_en(a_add),
    .ks_valid(a_ks_valid), .block_inc(a_block_inc), .done(a_done)
`ifdef CHACHA_SEQ_BLKCNT_EN
    , .blk_cnt(a_blk_cnt)
`endif
  );

  chacha_round_sequencer #(.ROUNDS(B_R), .QR_CYCLES(B_Q), .RW(RW)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .abort(b_abort),
    .ks_ready(b_ready), .busy(b_busy), .load_state(b_load), .qr_en(b_qr_en),
    .qr_idx(b_qr_idx), .diag(b_diag), .round_idx(b_round_idx), .add_en(b_add),
    .ks_valid(b_ks_valid), .block_inc(b_block_inc), .done(b_done)
`ifdef CHACHA_SEQ_BLKCNT_EN
    , .blk_cnt(b_blk_cnt)
`endif
  );

  // Observation mux for the selected instance.
  bit            dsel = 1'b0;
  logic          m_busy, m_load, m_qr_en, m_diag, m_add, m_ks_valid, m_block_inc, m_done;
  logic [1:0]    m_qr_idx;
  logic [RW-1:0] m_round_idx;
  assign m_busy      = dsel ? b_busy      : a_busy;
  assign m_load      = dsel ? b_load      : a_load;
  assign m_qr_en     = dsel ? b_qr_en     : a_qr_en;
  assign m_diag      = dsel ? b_diag      : a_diag;
  assign m_add       = dsel ? b_add       : a_add;
  assign m_ks_valid  = dsel ? b_ks_valid  : a_ks_valid;
  assign m_block_inc = dsel ? b_block_inc : a_block_inc;
  assign m_done      = dsel ? b_done      : a_done;
  assign m_qr_idx    = dsel ? b_qr_idx    : a_qr_idx;
  assign m_round_idx = dsel ? b_round_idx : a_round_idx;

  int checks = 0;
  int errors = 0;
  int exp_lat_q[$];
  int a_done_cnt = 0;
  int b_done_cnt = 0;

  always @(posedge clk) begin
    if (a_done) a_done_cnt <= a_done_cnt + 1;
    if (b_done) b_done_cnt <= b_done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_start(input logic v);
    if (dsel) b_start = v; else a_start = v;
  endtask

  task automatic set_ready(input logic v);
    if (dsel) b_ready = v; else a_ready = v;
  endtask

  function automatic int done_cnt();
    return dsel ? b_done_cnt : a_done_cnt;
  endfunction

  // One full block on the selected instance. c counts edges after the start
  // edge E0 at each negedge sample: c=0 LOAD, c=1..4RQ QR, ADD, then OUT.
  task automatic run_block(input int rounds, input int qrc, input int ready_delay,
                           input int inject_round, input bit start_at_hs);
    int c, k, adds, done0, lat, qr_total;
    bit seen;
    qr_total = 4 * rounds * qrc;
    done0    = done_cnt();
    @(negedge clk);
    set_start(1'b1);
    exp_lat_q.push_back(2 + qr_total);
    @(negedge clk);
    set_start(1'b0);
    check("load_state", m_load, 1);
    check("busy_in_load", m_busy, 1);
    c = 0; adds = 0; seen = 1'b0;
    while (!seen && c < 4000) begin
      @(negedge clk);
      c++;
      set_start(1'b0);
      if (m_add) adds++;
      if (m_ks_valid) begin
        seen = 1'b1;
      end else if (c - 1 < qr_total) begin
        k = c - 1;
        check("qr_en", m_qr_en, 1);
        check("qr_idx", m_qr_idx, (k / qrc) % 4);
        check("round_idx", m_round_idx, k / (4 * qrc));
        check("diag", m_diag, (k / (4 * qrc)) % 2);
        check("no_done_in_qr", m_done, 0);
        if (inject_round >= 0 && k == inject_round * 4 * qrc) set_start(1'b1);
      end
    end
    if (!seen) begin
      check("ks_valid_timeout", 0, 1);
      return;
    end
    lat = exp_lat_q.pop_front();
    check("ks_valid_latency", c, lat);
    check("add_en_pulses", adds, 1);
    for (int i = 0; i < ready_delay; i++) begin
      check("hold_ks_valid", m_ks_valid, 1);
      check("hold_busy", m_busy, 1);
      check("hold_no_done", m_done, 0);
      check("hold_round_idx", m_round_idx, rounds - 1);
      @(negedge clk);
    end
    set_ready(1'b1);
    if (start_at_hs) set_start(1'b1);
    #1;
    check("done_pulse", m_done, 1);
    check("block_inc_pulse", m_block_inc, 1);
    @(negedge clk);
    set_ready(1'b0);
    set_start(1'b0);
    #1;
    check("busy_after_hs", m_busy, 0);
    check("ks_valid_after_hs", m_ks_valid, 0);
    check("done_single", m_done, 0);
    if (start_at_hs) begin
      @(negedge clk);
      check("start_at_hs_ignored", m_busy, 0);
    end
    check("done_count", done_cnt() - done0, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int done0;
    bit found;

    // Reset state.
    repeat (3) @(negedge clk);
    a_ready = 1'b1;
    #1;
    check("rst_busy", a_busy, 0);
    check("rst_qr_en", a_qr_en, 0);
    check("rst_load", a_load, 0);
    check("rst_qr_idx", a_qr_idx, 0);
    check("rst_round_idx", a_round_idx, 0);
    check("rst_ks_valid", a_ks_valid, 0);
    check("rst_done_with_ready", a_done, 0);
    check("rst_b_busy", b_busy, 0);
`ifdef CHACHA_SEQ_BLKCNT_EN
    check("rst_blk_cnt", a_blk_cnt, 0);
`endif
    a_ready = 1'b0;
    reset_n = 1'b1;

    dsel = 1'b0;
    // Full sequence with ks_ready held low for 10 cycles in OUT.
    run_block(A_R, A_Q, 10, -1, 1'b0);
    // start during round 7 is ignored; start with the handshake is dropped.
    run_block(A_R, A_Q, 0, 7, 1'b1);

    // Abort at round 10, qr_idx 2.
    done0 = a_done_cnt;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (a_qr_en && a_round_idx == 5'd10 && a_qr_idx == 2'd2) found = 1'b1;
    end
    check("abort_point_reached", found, 1);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    check("abort_busy", a_busy, 0);
    check("abort_qr_idx", a_qr_idx, 0);
    check("abort_round_idx", a_round_idx, 0);
    check("abort_ks_valid", a_ks_valid, 0);
    for (int i = 0; i < 5; i++) begin
      check("abort_no_add", a_add, 0);
      @(negedge clk);
    end
    check("abort_no_done", a_done_cnt - done0, 0);

    // Fresh start after abort gives the full sequence.
    run_block(A_R, A_Q, 0, -1, 1'b0);
`ifdef CHACHA_SEQ_BLKCNT_EN
    check("blk_cnt_three", a_blk_cnt, 3);
`endif

    // Alternate configuration: 8 rounds, 3 cycles per quarter-round.
    dsel = 1'b1;
    run_block(B_R, B_Q, 2, -1, 1'b0);
    dsel = 1'b0;

    // Asynchronous reset in the middle of QR.
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (30) @(negedge clk);
    check("pre_reset_busy", a_busy, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_busy", a_busy, 0);
    check("async_rst_qr_en", a_qr_en, 0);
    check("async_rst_qr_idx", a_qr_idx, 0);
    check("async_rst_round_idx", a_round_idx, 0);
    check("async_rst_diag", a_diag, 0);
`ifdef CHACHA_SEQ_BLKCNT_EN
    check("async_rst_blk_cnt", a_blk_cnt, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    check("scoreboard_empty", exp_lat_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
